// File: rtl/pcs_rx_stimulus_gen_if.sv
// rtl/pcs_rx_stimulus_gen_if.sv - frame request and SUDI bundle for the PCS RX stimulus generator
interface pcs_rx_stimulus_gen_if #(
  parameter int LEN_W = 8
);
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic [7:0]       START_BYTE;
  logic             ERR_EN;
  logic [LEN_W-1:0] ERR_POS;
  logic [10:0]      SUDI;
  logic             SYNC_STATUS;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, LEN, START_BYTE, ERR_EN, ERR_POS,
    input  SUDI, SYNC_STATUS, BUSY, DONE
  );

  modport slave (
    input  START, LEN, START_BYTE, ERR_EN, ERR_POS,
    output SUDI, SYNC_STATUS, BUSY, DONE
  );
endinterface

// File: rtl/pcs_rx_stimulus_gen.sv
// rtl/pcs_rx_stimulus_gen.sv - 8b/10b IDLE/frame generator driving a 1000BASE-X PCS receiver SUDI
module pcs_rx_stimulus_gen #(
  parameter int LEN_W      = 8,
  parameter int SYNC_IDLES = 3,
  parameter int IPG_MIN    = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  pcs_rx_stimulus_gen_if.slave  gen
);

  localparam int IC_W = $clog2(SYNC_IDLES + 2);
  localparam int IG_W = $clog2(IPG_MIN + 2);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  typedef enum logic [2:0] {
    S_IDLE_K, S_IDLE_D, S_SOF, S_DATA, S_EOF_T, S_EOF_R, S_EOF_R2
  } state_t;

  // Returns {rd_out, abcdei, fghj}; rd = 1 means positive running disparity.
  function automatic logic [10:0] enc8b10b(input logic [7:0] d, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six;
    logic [3:0] four;
    logic       rd1, a7, unbal6, unbal4, comp6, comp4;
    x = d[4:0];
    y = d[7:5];
    case (x)
      5'd0:  six = 6'b100111;  5'd1:  six = 6'b011101;  5'd2:  six = 6'b101101;  5'd3:  six = 6'b110001;
      5'd4:  six = 6'b110101;  5'd5:  six = 6'b101001;  5'd6:  six = 6'b011001;  5'd7:  six = 6'b111000;
      5'd8:  six = 6'b111001;  5'd9:  six = 6'b100101;  5'd10: six = 6'b010101;  5'd11: six = 6'b110100;
      5'd12: six = 6'b001101;  5'd13: six = 6'b101100;  5'd14: six = 6'b011100;  5'd15: six = 6'b010111;
      5'd16: six = 6'b011011;  5'd17: six = 6'b100011;  5'd18: six = 6'b010011;  5'd19: six = 6'b110010;
      5'd20: six = 6'b001011;  5'd21: six = 6'b101010;  5'd22: six = 6'b011010;  5'd23: six = 6'b111010;
      5'd24: six = 6'b110011;  5'd25: six = 6'b100110;  5'd26: six = 6'b010110;  5'd27: six = 6'b110110;
      5'd28: six = 6'b001110;  5'd29: six = 6'b101110;  5'd30: six = 6'b011110;  default: six = 6'b101011;
    endcase
    if (k && x == 5'd28) six = 6'b001111;
    unbal6 = ($countones(six) != 3);
    // D.7 is balanced yet still has a distinct RD+ form
    comp6  = rd_in && (unbal6 || (x == 5'd7 && !k));
    rd1    = unbal6 ? ~rd_in : rd_in;
    a7     = (!rd1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( rd1 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    if (k) begin
      case (y)
        3'd0: four = 4'b1011;  3'd1: four = 4'b0110;  3'd2: four = 4'b1010;  3'd3: four = 4'b1100;
        3'd4: four = 4'b1101;  3'd5: four = 4'b0101;  3'd6: four = 4'b1001;  default: four = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: four = 4'b1011;  3'd1: four = 4'b1001;  3'd2: four = 4'b0101;  3'd3: four = 4'b1100;
        3'd4: four = 4'b1101;  3'd5: four = 4'b1010;  3'd6: four = 4'b0110;
        default: four = a7 ? 4'b0111 : 4'b1110;
      endcase
    end
    unbal4 = ($countones(four) != 2);
    comp4  = rd1 && (k || unbal4 || y == 3'd3);
    return {unbal4 ? ~rd1 : rd1, comp6 ? ~six : six, comp4 ? ~four : four};
  endfunction

  state_t           state;
  logic             rd, even;
  logic [IC_W-1:0]  idle_cnt;
  logic [IG_W-1:0]  ipg_cnt;
  logic [LEN_W-1:0] len_q, err_pos_q, idx;
  logic [7:0]       cur_byte;
  logic             err_q;

  logic [7:0]       sym;
  logic             is_k, err_slot, rd_nxt;
  logic [10:0]      enc;
  logic [9:0]       code_nxt;
  logic [IC_W-1:0]  idle_inc;
  logic [IG_W-1:0]  ipg_inc;

  always_comb begin
    sym      = 8'h00;
    is_k     = 1'b0;
    err_slot = 1'b0;
    case (state)
      S_IDLE_K: begin sym = K28_5; is_k = 1'b1; end
      S_IDLE_D: sym = rd ? D16_2 : D5_6;
      S_SOF:    begin sym = K27_7; is_k = 1'b1; end
      S_DATA:   begin sym = cur_byte; err_slot = err_q && (idx == err_pos_q); end
      S_EOF_T:  begin sym = K29_7; is_k = 1'b1; end
      default:  begin sym = K23_7; is_k = 1'b1; end
    endcase
    enc      = enc8b10b(sym, is_k, rd);
    code_nxt = err_slot ? 10'd0 : enc[9:0];
    rd_nxt   = err_slot ? rd : enc[10];
    idle_inc = (idle_cnt >= IC_W'(SYNC_IDLES)) ? idle_cnt : idle_cnt + IC_W'(1);
    ipg_inc  = (ipg_cnt >= IG_W'(IPG_MIN)) ? ipg_cnt : ipg_cnt + IG_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= S_IDLE_K;
      rd              <= 1'b0;
      even            <= 1'b1;
      idle_cnt        <= '0;
      ipg_cnt         <= IG_W'(IPG_MIN);
      len_q           <= '0;
      err_pos_q       <= '0;
      idx             <= '0;
      cur_byte        <= 8'h00;
      err_q           <= 1'b0;
      gen.SUDI        <= 11'd0;
      gen.SYNC_STATUS <= 1'b0;
      gen.BUSY        <= 1'b0;
      gen.DONE        <= 1'b0;
    end else begin
      gen.SUDI <= {even, code_nxt};
      rd       <= rd_nxt;
      even     <= ~even;
      gen.DONE <= 1'b0;
      if (gen.DONE) begin
        gen.BUSY <= 1'b0;
        ipg_cnt  <= '0;
      end
      if (gen.START && !gen.BUSY && gen.LEN != '0) begin
        gen.BUSY  <= 1'b1;
        len_q     <= gen.LEN;
        cur_byte  <= gen.START_BYTE;
        err_q     <= gen.ERR_EN;
        err_pos_q <= gen.ERR_POS;
      end
      case (state)
        S_IDLE_K: state <= S_IDLE_D;
        S_IDLE_D: begin
          idle_cnt <= idle_inc;
          ipg_cnt  <= ipg_inc;
          if (idle_inc >= IC_W'(SYNC_IDLES)) gen.SYNC_STATUS <= 1'b1;
          // BUSY here can only mean a captured frame still waiting for launch
          if (gen.BUSY && idle_inc >= IC_W'(SYNC_IDLES) && ipg_inc >= IG_W'(IPG_MIN))
            state <= S_SOF;
          else
            state <= S_IDLE_K;
        end
        S_SOF: begin
          idx   <= '0;
          state <= S_DATA;
        end
        S_DATA: begin
          idx      <= idx + LEN_W'(1);
          cur_byte <= cur_byte + 8'd1;
          if (idx == len_q - LEN_W'(1)) state <= S_EOF_T;
        end
        S_EOF_T: state <= S_EOF_R;
        S_EOF_R: begin
          // an /R/ on an even slot needs a second one so the next comma lands even
          if (even) begin
            state <= S_EOF_R2;
          end else begin
            gen.DONE <= 1'b1;
            state    <= S_IDLE_K;
          end
        end
        default: begin
          gen.DONE <= 1'b1;
          state    <= S_IDLE_K;
        end
      endcase
    end
  end

endmodule
